// File: rtl/lzd_normalizer.sv
// -----------------------------------------------------------------------------
// lzd_normalizer
//
// Multi-cycle normalizing left shifter placed after the 64-bit leading-zero
// detector. An accepted operand is shifted left by its leading-zero count,
// using a coarse step of big_step bits per cycle while at least big_step
// positions remain, then single-bit steps. The block reports the normalized
// word, the original position of the leading one, a zero flag, and a
// consistency error when a nonzero result does not end with its MSB set.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset (clears all state/outputs)
//   start        request, accepted only while busy = 0
//   data_in      operand, latched on acceptance
//   lz_count     leading-zero count from the detector
//   all_zero_in  operand is all zeros
//   norm_out     normalized operand
//   msb_pos      original index of the leading one (width-1-lz_count)
//   zero         result is zero
//   norm_err     nonzero result whose MSB is clear (count disagrees with data)
//   busy         operation in flight
//   done         result valid, held until the next accepted start
// -----------------------------------------------------------------------------
module lzd_normalizer #(
    parameter int width       = 64,
    parameter int count_width = 7,
    parameter int big_step    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [width-1:0]       data_in,
    input  logic [count_width-1:0] lz_count,
    input  logic                   all_zero_in,
    output logic [width-1:0]       norm_out,
    output logic [count_width-1:0] msb_pos,
    output logic                   zero,
    output logic                   norm_err,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [count_width-1:0] width_c = count_width'(width);
    localparam logic [count_width-1:0] last_c  = count_width'(width - 1);
    localparam logic [count_width-1:0] step_c  = count_width'(big_step);
    localparam logic [count_width-1:0] one_c   = count_width'(1);
    localparam logic [count_width-1:0] nil_c   = count_width'(0);

    state_t                 state_r;
    logic [width-1:0]       shreg_r;
    logic [count_width-1:0] remaining_r;
    logic [count_width-1:0] lz_r;
    logic                   zero_flag_r;

    logic [width-1:0]       shift_next_s;
    logic [count_width-1:0] rem_next_s;
    logic                   accept_s;
    logic                   zero_case_s;
    logic                   direct_s;

    // Acceptance decode: zero operands and out-of-range counts finish at once,
    // as do operands that are already normalized (count of zero).
    always_comb begin
        accept_s    = start && !busy;
        zero_case_s = all_zero_in || (lz_count >= width_c);
        direct_s    = zero_case_s || (lz_count == nil_c);
    end

    // One shift step: coarse step while enough distance remains, else one bit.
    always_comb begin
        shift_next_s = shreg_r;
        rem_next_s   = remaining_r;
        if (remaining_r >= step_c) begin
            shift_next_s = {shreg_r[width-big_step-1:0], {big_step{1'b0}}};
            rem_next_s   = remaining_r - step_c;
        end else begin
            shift_next_s = {shreg_r[width-2:0], 1'b0};
            rem_next_s   = remaining_r - one_c;
        end
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shreg_r     <= {width{1'b0}};
            remaining_r <= nil_c;
            lz_r        <= nil_c;
            zero_flag_r <= 1'b0;
            norm_out    <= {width{1'b0}};
            msb_pos     <= nil_c;
            zero        <= 1'b0;
            norm_err    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r     <= data_in;
                        remaining_r <= lz_count;
                        lz_r        <= lz_count;
                        zero_flag_r <= zero_case_s;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        zero        <= 1'b0;
                        norm_err    <= 1'b0;
                        state_r     <= direct_s ? DONE : SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg_r     <= shift_next_s;
                    remaining_r <= rem_next_s;
                    if (rem_next_s == nil_c) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    // A zero result reports a cleared word and position.
                    if (zero_flag_r) begin
                        norm_out <= {width{1'b0}};
                        msb_pos  <= nil_c;
                        norm_err <= 1'b0;
                    end else begin
                        norm_out <= shreg_r;
                        msb_pos  <= last_c - lz_r;
                        norm_err <= ~shreg_r[width-1];
                    end
                    zero    <= zero_flag_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzd_normalizer.sv
module tb_lzd_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] data_in;
    logic [6:0]  lz_count;
    logic        all_zero_in;
    logic [63:0] norm_out;
    logic [6:0]  msb_pos;
    logic        zero;
    logic        norm_err;
    logic        busy;
    logic        done;

    typedef struct {
        logic [63:0] norm;
        logic [6:0]  msb;
        logic        z;
        logic        e;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    lzd_normalizer #(.width(64), .count_width(7), .big_step(8)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .lz_count(lz_count), .all_zero_in(all_zero_in), .norm_out(norm_out),
        .msb_pos(msb_pos), .zero(zero), .norm_err(norm_err), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Scoreboard monitor: pops one expectation on every rising done.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_q = 1'b0;
            end else begin
                if (done && !done_q) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("norm_out", norm_out, e.norm);
                        chk("msb_pos", {57'd0, msb_pos}, {57'd0, e.msb});
                        chk("zero", {63'd0, zero}, {63'd0, e.z});
                        chk("norm_err", {63'd0, norm_err}, {63'd0, e.e});
                        chk("done_cycle", 64'(cyc), 64'(e.due));
                        chk("busy_at_done", {63'd0, busy}, 64'd0);
                    end
                end
                done_q = done;
            end
        end
    end

    // Apply one operand once busy is low; optionally queue its expected result.
    task automatic issue(input logic [63:0] d, input logic [6:0] lz, input logic az,
                         input bit push, input logic [63:0] en, input logic [6:0] em,
                         input logic ez, input logic ee, input int lat);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: busy stuck high, expected low");
        end
        start = 1'b1;
        data_in = d;
        lz_count = lz;
        all_zero_in = az;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.norm = en; e.msb = em; e.z = ez; e.e = ee; e.due = cyc + lat;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_norm_out"}, norm_out, 64'd0);
        chk({nm, "_msb_pos"}, {57'd0, msb_pos}, 64'd0);
        chk({nm, "_flags"}, {60'd0, zero, norm_err, busy, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int lz;
        int lat;
        rst = 1'b1;
        start = 1'b0;
        data_in = 64'd0;
        lz_count = 7'd0;
        all_zero_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        issue(64'h0000_0000_0000_0001, 7'd63, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 7'd0, 1'b0, 1'b0, 15);
        drain();
        issue(64'h8000_0000_0000_0000, 7'd0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 7'd63, 1'b0, 1'b0, 1);
        drain();
        issue(64'h0, 7'd64, 1'b1, 1'b1, 64'h0, 7'd0, 1'b1, 1'b0, 1);
        drain();
        issue(64'h00F0_0000_0000_0000, 7'd8, 1'b0, 1'b1, 64'hF000_0000_0000_0000, 7'd55, 1'b0, 1'b0, 2);
        drain();
        issue(64'h00F0_0000_0000_0000, 7'd7, 1'b0, 1'b1, 64'h7800_0000_0000_0000, 7'd56, 1'b0, 1'b1, 8);
        drain();

        // start while busy must be ignored
        issue(64'h0000_0000_0000_0001, 7'd63, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 7'd0, 1'b0, 1'b0, 15);
        @(negedge clk);
        start = 1'b1;
        data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        lz_count = 7'd0;
        all_zero_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", {63'd0, busy}, 64'd1);
        chk("done_after_ignored_start", {63'd0, done}, 64'd0);
        drain();

        // reset in the third SHIFT cycle of an lz=63 run
        issue(64'h0000_0000_0000_0001, 7'd63, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_all_zero("after_abort");

        // back-to-back operands with detector-style counts
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom};
            d = d >> $urandom_range(0, 64);
            lz = 64;
            for (int b = 63; b >= 0; b--) begin
                if (d[b] && lz == 64) lz = 63 - b;
            end
            if (lz == 64) begin
                issue(d, 7'd64, 1'b1, 1'b1, 64'h0, 7'd0, 1'b1, 1'b0, 1);
            end else begin
                lat = (lz == 0) ? 1 : (lz / 8 + lz % 8 + 1);
                issue(d, 7'(lz), 1'b0, 1'b1, d << lz, 7'(63 - lz), 1'b0, 1'b0, lat);
            end
        end
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
